pong_match_ctrl: RTL
====================

Name: pong_match_ctrl

Overview:
Parametrised match/score controller for the Pong datapath. It owns the per-player scores, win detection, serve countdown, pause and keyboard restart, and the free-running game tick. Ball and paddle logic consume its tick, serve-enable and restart pulse, and the VGA overlay consumes its scores and winner. It generalises the fixed 2-player, 7-point scoring and 'R'-key restart handling to N players, a configurable win score, and adds serve delay, pause and PS/2 break-code filtering.

Parameters:
NUM_PLAYERS, 2, number of scoring channels (2..8)
SCORE_W, 3, bits per score; WIN_SCORE < 2^SCORE_W
WIN_SCORE, 7, score that ends the match
TICK_W, 20, game tick period = 2^TICK_W clk cycles
SERVE_TICKS, 32, game ticks between a point and the next serve (>=1)
RESET_CODE, 8'h2D, PS/2 make code for restart ('R')
PAUSE_CODE, 8'h4D, PS/2 make code for pause toggle ('P')

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  asynchronous, active-high reset
point  in  NUM_PLAYERS  one-cycle pulse; bit i = player i scored
scan_code  in  8  PS/2 byte, valid when scan_ready
scan_ready  in  1  one-cycle strobe per received byte
game_tick  out  1  one-cycle pulse every 2^TICK_W cycles
serve_en  out  1  1 = ball may move (PLAY state only)
game_rst  out  1  one-cycle restart pulse to ball/paddle blocks
scores  out  NUM_PLAYERS*SCORE_W  packed; player i at [i*SCORE_W +: SCORE_W]
last_scorer  out  clog2(NUM_PLAYERS)  index of the most recent scorer (serve direction)
winner  out  clog2(NUM_PLAYERS)  valid when game_over
game_over  out  1  match finished
state  out  2  0=SERVE, 1=PLAY, 2=PAUSED, 3=OVER

Behaviour:
- Reset (async, on assertion): state=SERVE, countdown=SERVE_TICKS, scores=0, last_scorer=0, winner=0, game_over=0, serve_en=0, game_rst=0, tick counter=0, game_tick=0, break flag=0, paused_from=SERVE.
- All outputs are registered. Every event sampled at edge n is visible at edge n+1.
- Tick counter: a TICK_W-bit free-running counter that wraps. game_tick=1 for the single cycle after the counter reaches 0. Only reset clears the counter; restart and pause do not affect it.
- Key filter: on scan_ready with scan_code=8'hF0, set the break flag. The next scan_ready byte is discarded and clears the flag. Bytes other than RESET_CODE and PAUSE_CODE are ignored.
- Restart (RESET_CODE make, any state): scores=0, game_over=0, winner=0, state=SERVE, countdown=SERVE_TICKS, game_rst=1 for exactly one cycle. Restart has the highest priority and discards a same-cycle point.
- Pause (PAUSE_CODE make): from SERVE or PLAY, save the state to paused_from and go to PAUSED. From PAUSED, return to paused_from with the countdown unchanged. Ignored in OVER.
- SERVE: serve_en=0. Each game_tick decrements the countdown. A game_tick that arrives when the countdown is 1 moves the state to PLAY. Points are ignored.
- PLAY: serve_en=1. On any point bit, select the lowest set index i; the other bits that cycle are dropped. score[i]+1 and last_scorer=i.
  - If the new score equals WIN_SCORE: go to OVER, game_over=1, winner=i.
  - Otherwise: go to SERVE and set countdown=SERVE_TICKS.
- PAUSED: serve_en=0. The countdown is frozen and points are ignored.
- OVER: serve_en=0. Scores are held. Only restart exits.
- Scores never exceed WIN_SCORE, and no wrap-around is possible.
- Reset asserted mid-match returns everything to the reset values immediately. No game_rst pulse is produced by reset.

Test Plan:
- Reset release, TICK_W=4, SERVE_TICKS=3 -> state=SERVE; PLAY and serve_en=1 one cycle after the 3rd game_tick; game_tick period = 16 cycles.
- In PLAY, pulse point=2'b10 -> next cycle scores[5:3]=1, last_scorer=1, state=SERVE, serve_en=0, countdown=3.
- Pulse point=2'b11 simultaneously in PLAY -> only player 0 increments (scores=6'b000_001).
- Player 0 at 6, point=2'b01 in PLAY -> score 7, game_over=1, winner=0, state=OVER; further point pulses leave scores unchanged.
- Send bytes 4D, then F0,4D, then 4D while in PLAY -> PAUSED after the first 4D; break pair ignored (still PAUSED); PLAY after the last 4D; game_tick pulses during PAUSED do not change the countdown.
- In OVER, send 2D -> one-cycle game_rst=1, scores=0, game_over=0, state=SERVE; tick counter phase unchanged.

Source files
------------

// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the Pong match controller and its game/overlay environment.
// The slave modport is the controller's view; master is the environment's view.
interface pong_match_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 3
);
  localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  logic [NUM_PLAYERS-1:0]         point;
  logic [7:0]                     scan_code;
  logic                           scan_ready;
  logic                           game_tick;
  logic                           serve_en;
  logic                           game_rst;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic [IDX_W-1:0]               last_scorer;
  logic [IDX_W-1:0]               winner;
  logic                           game_over;
  logic [1:0]                     state;

  modport master (
    output point, scan_code, scan_ready,
    input  game_tick, serve_en, game_rst, scores, last_scorer, winner, game_over, state
  );

  modport slave (
    input  point, scan_code, scan_ready,
    output game_tick, serve_en, game_rst, scores, last_scorer, winner, game_over, state
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match controller: per-player scores, win detection, serve countdown,
// pause, PS/2 keyboard restart and the free-running game tick.
module pong_match_ctrl #(
  parameter int         NUM_PLAYERS = 2,
  parameter int         SCORE_W     = 3,
  parameter int         WIN_SCORE   = 7,
  parameter int         TICK_W      = 20,
  parameter int         SERVE_TICKS = 32,
  parameter logic [7:0] RESET_CODE  = 8'h2D,
  parameter logic [7:0] PAUSE_CODE  = 8'h4D
) (
  input  logic             clk,
  input  logic             reset,
  pong_match_ctrl_if.slave bus
);
  localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CNT_W = $clog2(SERVE_TICKS + 1);

  typedef enum logic [1:0] {
    ST_SERVE  = 2'd0,
    ST_PLAY   = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  state_t                         r_state;
  state_t                         r_paused_from;
  logic [TICK_W-1:0]              r_tick_cnt;
  logic                           r_game_tick;
  logic [CNT_W-1:0]               r_countdown;
  logic [NUM_PLAYERS*SCORE_W-1:0] r_scores;
  logic [IDX_W-1:0]               r_last;
  logic [IDX_W-1:0]               r_winner;
  logic                           r_over;
  logic                           r_serve_en;
  logic                           r_game_rst;
  logic                           r_break;

  logic                           w_key_valid;
  logic                           w_restart;
  logic                           w_pause;
  logic                           w_found;
  logic [IDX_W-1:0]               w_sel_idx;
  logic [SCORE_W-1:0]             w_sel_score;
  logic [NUM_PLAYERS*SCORE_W-1:0] w_scores_inc;
  logic                           w_win;

  // The byte right after an F0 prefix is a key release and never acts as a command.
  assign w_key_valid = bus.scan_ready && !r_break && (bus.scan_code != 8'hF0);
  assign w_restart   = w_key_valid && (bus.scan_code == RESET_CODE);
  assign w_pause     = w_key_valid && (bus.scan_code == PAUSE_CODE);

  // Lowest-index scorer wins a simultaneous point; the others are dropped.
  always_comb begin
    w_found      = 1'b0;
    w_sel_idx    = '0;
    w_sel_score  = '0;
    w_scores_inc = r_scores;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (bus.point[i] && !w_found) begin
        w_found      = 1'b1;
        w_sel_idx    = IDX_W'(i);
        w_sel_score  = r_scores[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
        w_scores_inc[i*SCORE_W +: SCORE_W] = w_sel_score;
      end
    end
  end

  assign w_win = (w_sel_score == SCORE_W'(WIN_SCORE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt    <= '0;
      r_game_tick   <= 1'b0;
      r_state       <= ST_SERVE;
      r_paused_from <= ST_SERVE;
      r_countdown   <= CNT_W'(SERVE_TICKS);
      r_scores      <= '0;
      r_last        <= '0;
      r_winner      <= '0;
      r_over        <= 1'b0;
      r_serve_en    <= 1'b0;
      r_game_rst    <= 1'b0;
      r_break       <= 1'b0;
    end else begin
      r_tick_cnt  <= r_tick_cnt + TICK_W'(1);
      r_game_tick <= (r_tick_cnt == '0);
      r_game_rst  <= 1'b0;

      if (bus.scan_ready) begin
        r_break <= r_break ? 1'b0 : (bus.scan_code == 8'hF0);
      end

      // Key commands take precedence over ticks and points in the same cycle.
      if (w_restart) begin
        r_scores    <= '0;
        r_over      <= 1'b0;
        r_winner    <= '0;
        r_state     <= ST_SERVE;
        r_countdown <= CNT_W'(SERVE_TICKS);
        r_game_rst  <= 1'b1;
        r_serve_en  <= 1'b0;
      end else if (w_pause && (r_state != ST_OVER)) begin
        if (r_state == ST_PAUSED) begin
          r_state    <= r_paused_from;
          r_serve_en <= (r_paused_from == ST_PLAY);
        end else begin
          r_paused_from <= r_state;
          r_state       <= ST_PAUSED;
          r_serve_en    <= 1'b0;
        end
      end else begin
        case (r_state)
          ST_SERVE: begin
            r_serve_en <= 1'b0;
            if (r_game_tick) begin
              if (r_countdown == CNT_W'(1)) begin
                r_state    <= ST_PLAY;
                r_serve_en <= 1'b1;
              end
              r_countdown <= r_countdown - CNT_W'(1);
            end
          end
          ST_PLAY: begin
            r_serve_en <= 1'b1;
            if (w_found) begin
              r_scores   <= w_scores_inc;
              r_last     <= w_sel_idx;
              r_serve_en <= 1'b0;
              if (w_win) begin
                r_state  <= ST_OVER;
                r_over   <= 1'b1;
                r_winner <= w_sel_idx;
              end else begin
                r_state     <= ST_SERVE;
                r_countdown <= CNT_W'(SERVE_TICKS);
              end
            end
          end
          default: r_serve_en <= 1'b0;
        endcase
      end
    end
  end

  assign bus.game_tick   = r_game_tick;
  assign bus.serve_en    = r_serve_en;
  assign bus.game_rst    = r_game_rst;
  assign bus.scores      = r_scores;
  assign bus.last_scorer = r_last;
  assign bus.winner      = r_winner;
  assign bus.game_over   = r_over;
  assign bus.state       = r_state;
endmodule
